// File: rtl/ddr2_refresh_sched.sv
// ddr2_refresh_sched: tREFI refresh cadence, owed-refresh tracking and PRE/REF command sequencing.
// Build option: define DDR2_REF_POSTPONE_EN to allow refreshes to be postponed while busy.
//
// state    | meaning
// IDLE     | no refresh in progress; controller owns the command path
// ARB      | command path claimed; one cycle for the controller to settle
// PRE      | presenting precharge-all, held until granted
// WAIT_RP  | tRP spacing after the precharge grant
// REF      | presenting REF, held until granted
// WAIT_RFC | tRFC spacing after the REF grant
module ddr2_refresh_sched #(
  parameter int unsigned T_REFI       = 7800,
  parameter int unsigned T_RP         = 15,
  parameter int unsigned T_RFC        = 105,
  parameter int unsigned MAX_POSTPONE = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       init_done,
  input  logic       ref_en,
  input  logic       busy,
  input  logic       all_idle,
  input  logic       cmd_gnt,
  output logic       cmd_req,
  output logic [3:0] cmd,
  output logic       cmd_a10,
  output logic       ref_active,
  output logic [3:0] pending,
  output logic       urgent,
  output logic       ref_done,
  output logic       ref_overflow
);

  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_REF = 4'b0001;

  localparam int unsigned MAX_CFG = (MAX_POSTPONE < 1) ? 1 :
                                    (MAX_POSTPONE > 15) ? 15 : MAX_POSTPONE;
`ifdef DDR2_REF_POSTPONE_EN
  localparam int unsigned MAX_EFF = MAX_CFG;
`else
  // postponing disabled: at most one refresh is ever owed
  localparam int unsigned MAX_EFF = (MAX_CFG > 1) ? 1 : MAX_CFG;
`endif
  localparam logic [3:0] PEND_MAX = 4'(MAX_EFF);

  localparam int unsigned IW   = (T_REFI > 1) ? $clog2(T_REFI) : 1;
  localparam int unsigned DMAX = (T_RFC > T_RP) ? T_RFC : T_RP;
  localparam int unsigned DW   = (DMAX > 1) ? $clog2(DMAX) : 1;

  localparam logic [IW-1:0] IVL_LOAD = IW'(T_REFI - 1);
  localparam logic [DW-1:0] RP_LOAD  = DW'(T_RP - 1);
  localparam logic [DW-1:0] RFC_LOAD = DW'(T_RFC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_PRE,
    S_WAIT_RP,
    S_REF,
    S_WAIT_RFC
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [IW-1:0] ivl_cnt;
  logic [DW-1:0] dly_cnt;
  logic [DW-1:0] dly_val;
  logic          dly_load;
  logic          burst;
  logic          burst_nxt;
  logic          soft_rst;
  logic          tick;
  logic          ref_fin;
  logic          ovf_set;
  logic [3:0]    pend_nxt;

  assign soft_rst = rst || !init_done;
  assign tick     = init_done && ref_en && (ivl_cnt == '0);
  assign ref_fin  = (state == S_WAIT_RFC) && (dly_cnt == '0);

  always_ff @(posedge clk) begin
    if (soft_rst || !ref_en) begin
      ivl_cnt <= IVL_LOAD;
    end else if (ivl_cnt == '0) begin
      ivl_cnt <= IVL_LOAD;
    end else begin
      ivl_cnt <= ivl_cnt - IW'(1);
    end
  end

  always_comb begin
    pend_nxt = pending;
    ovf_set  = 1'b0;
    if (tick && !ref_fin) begin
      if (pending >= PEND_MAX) begin
        ovf_set = 1'b1;
      end else begin
        pend_nxt = pending + 4'd1;
      end
    end else if (!tick && ref_fin && (pending != '0)) begin
      pend_nxt = pending - 4'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    burst_nxt = burst;
    dly_load  = 1'b0;
    dly_val   = '0;
    case (state)
      S_IDLE: begin
        if ((pending != '0) && ref_en && (urgent || !busy)) begin
          state_nxt = S_ARB;
          burst_nxt = urgent;
        end
      end
      S_ARB: begin
        state_nxt = all_idle ? S_REF : S_PRE;
      end
      S_PRE: begin
        if (cmd_gnt) begin
          state_nxt = S_WAIT_RP;
          dly_load  = 1'b1;
          dly_val   = RP_LOAD;
        end
      end
      S_WAIT_RP: begin
        if (dly_cnt == '0) begin
          state_nxt = S_REF;
        end
      end
      S_REF: begin
        if (cmd_gnt) begin
          state_nxt = S_WAIT_RFC;
          dly_load  = 1'b1;
          dly_val   = RFC_LOAD;
        end
      end
      S_WAIT_RFC: begin
        // a sequence started by urgency drains the whole backlog, even while busy
        if (dly_cnt == '0) begin
          if ((pend_nxt != '0) && ref_en && (urgent || burst || !busy)) begin
            state_nxt = S_REF;
          end else begin
            state_nxt = S_IDLE;
            burst_nxt = 1'b0;
          end
        end
      end
      default: begin
        state_nxt = S_IDLE;
        burst_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (soft_rst) begin
      state      <= S_IDLE;
      burst      <= 1'b0;
      dly_cnt    <= '0;
      pending    <= '0;
      urgent     <= 1'b0;
      ref_done   <= 1'b0;
      cmd_req    <= 1'b0;
      cmd        <= CMD_NOP;
      cmd_a10    <= 1'b0;
      ref_active <= 1'b0;
    end else begin
      state   <= state_nxt;
      burst   <= burst_nxt;
      if (dly_load) begin
        dly_cnt <= dly_val;
      end else if (dly_cnt != '0) begin
        dly_cnt <= dly_cnt - DW'(1);
      end
      pending    <= pend_nxt;
      urgent     <= (pending >= PEND_MAX);
      ref_done   <= ref_fin;
      cmd_req    <= (state_nxt == S_PRE) || (state_nxt == S_REF);
      cmd        <= (state_nxt == S_PRE) ? CMD_PRE :
                    (state_nxt == S_REF) ? CMD_REF : CMD_NOP;
      cmd_a10    <= (state_nxt == S_PRE);
      ref_active <= (state_nxt != S_IDLE);
    end
  end

  // survives init_done dropping; only a real reset clears it
  always_ff @(posedge clk) begin
    if (rst) begin
      ref_overflow <= 1'b0;
    end else if (ovf_set) begin
      ref_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ddr2_refresh_sched.sv
// Directed bench for ddr2_refresh_sched: a vector table for the basic sequences,
// hand-written runs for stall, reset, overflow and postponed-burst behaviour.
module tb_ddr2_refresh_sched;

  localparam logic [3:0] NOP = 4'b0111;
  localparam logic [3:0] PRE = 4'b0010;
  localparam logic [3:0] REF = 4'b0001;
`ifdef DDR2_REF_POSTPONE_EN
  localparam int EXP_MAX = 8;
  localparam int EXP_NPRE = 1;
`else
  localparam int EXP_MAX = 1;
  localparam int EXP_NPRE = 8;
`endif

  logic       clk;
  logic       rst, init_done, ref_en, busy, all_idle, cmd_gnt;
  logic       cmd_req, cmd_a10, ref_active, urgent, ref_done, ref_overflow;
  logic [3:0] cmd, pending;

  int n_tests = 0;
  int n_fail  = 0;

  ddr2_refresh_sched #(
    .T_REFI(100), .T_RP(3), .T_RFC(10), .MAX_POSTPONE(8)
  ) dut (
    .clk(clk), .rst(rst), .init_done(init_done), .ref_en(ref_en), .busy(busy),
    .all_idle(all_idle), .cmd_gnt(cmd_gnt), .cmd_req(cmd_req), .cmd(cmd),
    .cmd_a10(cmd_a10), .ref_active(ref_active), .pending(pending), .urgent(urgent),
    .ref_done(ref_done), .ref_overflow(ref_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit          rst, init, en, busy, idle, gnt;
    int          n;
    logic [13:0] exp;
  } vec_t;

  vec_t tv[$];

  function automatic logic [13:0] ev(input logic req, input logic [3:0] c, input logic a10,
                                     input logic act, input logic [3:0] pend, input logic urg,
                                     input logic done, input logic ovf);
    return {req, c, a10, act, pend, urg, done, ovf};
  endfunction

  task automatic add(input string nm, input bit r, input bit i, input bit e, input bit b,
                     input bit idl, input bit g, input int n, input logic [13:0] x);
    vec_t v;
    v.name = nm; v.rst = r; v.init = i; v.en = e; v.busy = b; v.idle = idl; v.gnt = g;
    v.n = n; v.exp = x;
    tv.push_back(v);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [13:0] x);
    logic [13:0] a;
    a = {cmd_req, cmd, cmd_a10, ref_active, pending, urgent, ref_done, ref_overflow};
    n_tests++;
    if (a !== x) begin
      n_fail++;
      $display("FAIL %s: got {req,cmd,a10,act,pend,urg,done,ovf}=%b expected %b", nm, a, x);
    end
  endtask

  task automatic check_int(input string nm, input int got, input int x);
    n_tests++;
    if (got != x) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, x);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; init_done = 1'b0; ref_en = 1'b1; busy = 1'b0; all_idle = 1'b1; cmd_gnt = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  initial begin
    logic u1;
    int   first_req, n_pre, n_ref, n_done, max_pend;
    u1 = (EXP_MAX == 1);

    // basic refresh without precharge, then a second one needing precharge-all
    add("reset",     1, 0, 1, 0, 1, 1,  2, ev(0, NOP, 0, 0, 0, 0,  0, 0));
    add("pre_tick",  0, 1, 1, 0, 1, 1, 99, ev(0, NOP, 0, 0, 0, 0,  0, 0));
    add("tick1",     0, 1, 1, 0, 1, 1,  1, ev(0, NOP, 0, 0, 1, 0,  0, 0));
    add("arb",       0, 1, 1, 0, 1, 1,  1, ev(0, NOP, 0, 1, 1, u1, 0, 0));
    add("ref",       0, 1, 1, 0, 1, 1,  1, ev(1, REF, 0, 1, 1, u1, 0, 0));
    add("ref_gnt",   0, 1, 1, 0, 1, 1,  1, ev(0, NOP, 0, 1, 1, u1, 0, 0));
    add("wait_rfc",  0, 1, 1, 0, 1, 1,  9, ev(0, NOP, 0, 1, 1, u1, 0, 0));
    add("done",      0, 1, 1, 0, 1, 1,  1, ev(0, NOP, 0, 0, 0, u1, 1, 0));
    add("idle",      0, 1, 1, 0, 1, 1,  1, ev(0, NOP, 0, 0, 0, 0,  0, 0));
    add("pre_tick2", 0, 1, 1, 0, 1, 1, 85, ev(0, NOP, 0, 0, 0, 0,  0, 0));
    add("tick2",     0, 1, 1, 0, 0, 1,  1, ev(0, NOP, 0, 0, 1, 0,  0, 0));
    add("arb2",      0, 1, 1, 0, 0, 1,  1, ev(0, NOP, 0, 1, 1, u1, 0, 0));
    add("pre",       0, 1, 1, 0, 0, 1,  1, ev(1, PRE, 1, 1, 1, u1, 0, 0));
    add("pre_gnt",   0, 1, 1, 0, 0, 1,  1, ev(0, NOP, 0, 1, 1, u1, 0, 0));
    add("wait_rp",   0, 1, 1, 0, 0, 1,  2, ev(0, NOP, 0, 1, 1, u1, 0, 0));
    add("ref2",      0, 1, 1, 0, 0, 1,  1, ev(1, REF, 0, 1, 1, u1, 0, 0));
    add("ref2_gnt",  0, 1, 1, 0, 0, 1,  1, ev(0, NOP, 0, 1, 1, u1, 0, 0));
    add("done2",     0, 1, 1, 0, 0, 1, 10, ev(0, NOP, 0, 0, 0, u1, 1, 0));

    for (int k = 0; k < tv.size(); k++) begin
      rst = tv[k].rst; init_done = tv[k].init; ref_en = tv[k].en;
      busy = tv[k].busy; all_idle = tv[k].idle; cmd_gnt = tv[k].gnt;
      step(tv[k].n);
      check(tv[k].name, tv[k].exp);
    end

    // grant withheld in REF, then reset in the middle of tRFC
    do_reset();
    init_done = 1'b1; cmd_gnt = 1'b0;
    step(102);
    check("stall_ref", ev(1, REF, 0, 1, 1, u1, 0, 0));
    for (int k = 0; k < 5; k++) begin
      step(1);
      check("stall_hold", ev(1, REF, 0, 1, 1, u1, 0, 0));
    end
    cmd_gnt = 1'b1;
    step(1);
    check("stall_gnt", ev(0, NOP, 0, 1, 1, u1, 0, 0));
    step(4);
    rst = 1'b1;
    step(1);
    check("rst_mid_rfc", ev(0, NOP, 0, 0, 0, 0, 0, 0));
    rst = 1'b0;

    // refreshes never granted: saturate, then lose a tick
    do_reset();
    init_done = 1'b1; busy = 1'b1; cmd_gnt = 1'b0;
    step(EXP_MAX * 100);
    check_int("sat_pending", int'(pending), EXP_MAX);
    step(99);
    check_int("ovf_before", int'(ref_overflow), 0);
    step(1);
    check("ovf_set", ev(1, REF, 0, 1, 4'(EXP_MAX), 1, 0, 1));
    init_done = 1'b0;
    step(2);
    check("ovf_keep_init", ev(0, NOP, 0, 0, 0, 0, 0, 1));
    init_done = 1'b1;
    step(3);
    check_int("ovf_keep2", int'(ref_overflow), 1);
    rst = 1'b1;
    step(1);
    check("ovf_rst", ev(0, NOP, 0, 0, 0, 0, 0, 0));
    rst = 1'b0;

    // busy for 850 cycles with open banks: count issued commands
    do_reset();
    init_done = 1'b1; busy = 1'b1; all_idle = 1'b0; cmd_gnt = 1'b1;
    first_req = 0; n_pre = 0; n_ref = 0; n_done = 0; max_pend = 0;
    for (int e = 1; e <= 899; e++) begin
      if (e == 851) busy = 1'b0;
      step(1);
      if (cmd_req) begin
        if (first_req == 0) first_req = e;
        if (cmd == PRE) n_pre++;
        if (cmd == REF) n_ref++;
      end
      if (ref_done) n_done++;
      if (int'(pending) > max_pend) max_pend = int'(pending);
    end
    check_int("busy_first_req", first_req, EXP_MAX * 100 + 3);
    check_int("busy_n_pre", n_pre, EXP_NPRE);
    check_int("busy_n_ref", n_ref, 8);
    check_int("busy_n_done", n_done, 8);
    check_int("busy_max_pend", max_pend, EXP_MAX);
    check_int("busy_pend_end", int'(pending), 0);
    check_int("busy_ovf", int'(ref_overflow), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
